// File: rtl/sub_serial_nibble_if.sv
// rtl/sub_serial_nibble_if.sv - start/busy/done operand and result bundle for sub_serial_nibble
interface sub_serial_nibble_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             borrow_out;
   logic             ovf;

   modport master (
      output start, a, b,
      input  busy, done, result, borrow_out, ovf
   );

   modport slave (
      input  start, a, b,
      output busy, done, result, borrow_out, ovf
   );
endinterface

// File: rtl/sub_serial_nibble.sv
// rtl/sub_serial_nibble.sv - nibble-serial a-b subtractor, LSB digit first; SUB_SAT_EN adds overflow clamping
module sub_serial_nibble #(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   sub_serial_nibble_if.slave bus
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;

   logic [4:0]       nib_sum;
   logic [WIDTH+3:0] res_cat;
   logic [WIDTH-1:0] res_full;
   logic             ovf_now;
`ifdef SUB_SAT_EN
   logic [WIDTH-1:0] sat_val;
`endif

   always_comb begin
      // One digit step: a + ~b + carry; res_full is the shadow after shifting this digit in.
      nib_sum  = {1'b0, a_sh_q[3:0]} + {1'b0, ~b_sh_q[3:0]} + {4'b0000, carry_q};
      res_cat  = {nib_sum[3:0], res_sh_q};
      res_full = res_cat[WIDTH+3:4];
      ovf_now  = (a_msb_q != b_msb_q) && (res_full[WIDTH-1] != a_msb_q);
`ifdef SUB_SAT_EN
      sat_val  = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               a_msb_d = bus.a[WIDTH-1];
               b_msb_d = bus.b[WIDTH-1];
               carry_d = 1'b1;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_sh_d   = a_sh_q >> 4;
            b_sh_d   = b_sh_q >> 4;
            res_sh_d = res_full;
            carry_d  = nib_sum[4];
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d  = S_DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               borrow_d = ~nib_sum[4];
               ovf_d    = ovf_now;
`ifdef SUB_SAT_EN
               result_d = ovf_now ? sat_val : res_full;
`else
               result_d = res_full;
`endif
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.result     = result_q;
   assign bus.borrow_out = borrow_q;
   assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_sub_serial_nibble.sv
// tb/tb_sub_serial_nibble.sv - directed and random checks of sub_serial_nibble against an arithmetic model
module tb_sub_serial_nibble;
   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;
   logic [15:0] last_res;
   logic        last_bor;
   logic        last_ovf;

   sub_serial_nibble_if #(.WIDTH(WIDTH)) ifc ();

   sub_serial_nibble #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void ref_sub(input logic [15:0] av, input logic [15:0] bv,
                                   output logic [15:0] r, output logic bo, output logic ov);
      logic [16:0] ud;
      int          sd;
      ud = {1'b0, av} - {1'b0, bv};
      sd = int'($signed(av)) - int'($signed(bv));
      r  = ud[15:0];
      bo = ud[16];
      ov = (sd > 32767) || (sd < -32768);
`ifdef SUB_SAT_EN
      if (ov) r = (sd > 0) ? 16'h7FFF : 16'h8000;
`endif
   endfunction

   // Starts an operation from IDLE or a DONE cycle and returns positioned in the done cycle.
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input bit noise, input string tag);
      logic [15:0] er;
      logic        eb, eo;
      ref_sub(av, bv, er, eb, eo);
      ifc.start = 1'b1;
      ifc.a     = av;
      ifc.b     = bv;
      tick();
      for (int i = 0; i < NIB; i++) begin
         ifc.start = noise;
         ifc.a     = 16'($urandom);
         ifc.b     = 16'($urandom);
         chk({tag, "_busy"}, ifc.busy, 1);
         chk({tag, "_nodone"}, ifc.done, 0);
         chk({tag, "_hold"}, ifc.result, last_res);
         tick();
      end
      ifc.start = 1'b0;
      chk({tag, "_done"}, ifc.done, 1);
      chk({tag, "_idle_busy"}, ifc.busy, 0);
      chk({tag, "_result"}, ifc.result, er);
      chk({tag, "_borrow"}, ifc.borrow_out, eb);
      chk({tag, "_ovf"}, ifc.ovf, eo);
      last_res = er;
      last_bor = eb;
      last_ovf = eo;
   endtask

   task automatic to_idle(input string tag);
      tick();
      chk({tag, "_done_pulse"}, ifc.done, 0);
      chk({tag, "_after_busy"}, ifc.busy, 0);
      chk({tag, "_after_res"}, ifc.result, last_res);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      last_res     = '0;
      last_bor     = 1'b0;
      last_ovf     = 1'b0;
      rst          = 1'b1;
      ifc.start    = 1'b0;
      ifc.a        = '0;
      ifc.b        = '0;
      tick();
      tick();
      chk("rst_busy", ifc.busy, 0);
      chk("rst_done", ifc.done, 0);
      chk("rst_result", ifc.result, 0);
      chk("rst_borrow", ifc.borrow_out, 0);
      chk("rst_ovf", ifc.ovf, 0);
      rst = 1'b0;
      tick();

      run_op(16'h1234, 16'h0234, 0, "t1");
      chk("t1_const", ifc.result, 16'h1000);
      to_idle("t1");
      run_op(16'h0000, 16'h0001, 0, "t2");
      chk("t2_const", ifc.result, 16'hFFFF);
      to_idle("t2");
      run_op(16'h8000, 16'h0001, 0, "t3");
      chk("t3_ovf_const", ifc.ovf, 1);
      to_idle("t3");
      run_op(16'h7FFF, 16'hFFFF, 0, "t4");
      chk("t4_bor_const", ifc.borrow_out, 1);
      to_idle("t4");

      run_op(16'h1111, 16'h0101, 1, "t5a");
      chk("t5a_const", ifc.result, 16'h1010);
      run_op(16'h0005, 16'h0003, 0, "t5b");
      chk("t5b_const", ifc.result, 16'h0002);
      to_idle("t5b");

      // Abort mid-run: reset lands on the second RUN edge.
      ifc.start = 1'b1;
      ifc.a     = 16'h1234;
      ifc.b     = 16'h0234;
      tick();
      ifc.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_res = '0;
      chk("t6_busy", ifc.busy, 0);
      chk("t6_done", ifc.done, 0);
      chk("t6_result", ifc.result, 0);
      chk("t6_borrow", ifc.borrow_out, 0);
      chk("t6_ovf", ifc.ovf, 0);
      for (int i = 0; i < NIB + 2; i++) begin
         tick();
         chk("t6_no_done", ifc.done, 0);
         chk("t6_no_busy", ifc.busy, 0);
      end
      run_op(16'h1234, 16'h0234, 0, "t6_fresh");
      to_idle("t6_fresh");

      // start and rst together: request dropped.
      rst       = 1'b1;
      ifc.start = 1'b1;
      ifc.a     = 16'h4321;
      ifc.b     = 16'h0001;
      tick();
      rst       = 1'b0;
      ifc.start = 1'b0;
      last_res  = '0;
      for (int i = 0; i < NIB + 2; i++) begin
         tick();
         chk("rst_start_busy", ifc.busy, 0);
         chk("rst_start_done", ifc.done, 0);
      end

      for (int n = 0; n < 40; n++) begin
         run_op(16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)), "rnd");
         if ($urandom_range(0, 1) == 0) to_idle("rnd");
      end
      to_idle("end");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
